// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port synchronous RAM between the core
//            instruction fetch (IF, read-only), the core data port (D) and a
//            host debug/loader port (DBG). One access in flight at a time.
//            Fixed priority DBG > D > IF, with IF forced to win after
//            STARVE_LIMIT consecutive lost arbitrations.
// Ports    : clk, rst_n            clock / async active-low reset
//            if_*  (req, addr -> ack, rdata)                IF read port
//            d_*   (req, we, addr, wdata -> ack, rdata)     data port
//            dbg_* (req, we, addr, wdata -> ack, rdata)     debug port
//            mem_* (en, we, addr, wdata -> ; <- rdata)      RAM side
//            busy_o   FSM not idle;  gnt_id_o  0 none, 1 IF, 2 D, 3 DBG
// Revision : 1.0  initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic [1:0]        gnt_id_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;
    localparam logic [1:0] GNT_DBG  = 2'd3;

    localparam logic [2:0] LAT_INIT   = 3'(RD_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]        state_q,  state_d;
    logic [1:0]        gnt_q,    gnt_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [2:0]        cnt_q,    cnt_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [3:0]        starve_q, starve_d;

    logic [1:0]        win_id;

    // Arbitration: a starved IF overrides the fixed DBG > D > IF order.
    always_comb begin
        win_id = GNT_NONE;
        if (if_req_i && (starve_q == STARVE_MAX)) begin
            win_id = GNT_IF;
        end else if (dbg_req_i) begin
            win_id = GNT_DBG;
        end else if (d_req_i) begin
            win_id = GNT_D;
        end else if (if_req_i) begin
            win_id = GNT_IF;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= GNT_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 3'd0;
            rdata_q  <= '0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        unique case (state_q)
            S_IDLE: begin
                // Count only arbitrations where IF asked and lost.
                if (if_req_i && (win_id != GNT_IF)) begin
                    if (starve_q < STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else begin
                    starve_d = 4'd0;
                end
                if (win_id != GNT_NONE) begin
                    state_d = S_ISSUE;
                    gnt_d   = win_id;
                    unique case (win_id)
                        GNT_IF: begin
                            we_d   = 1'b0;
                            addr_d = if_addr_i;
                        end
                        GNT_D: begin
                            we_d    = d_we_i;
                            addr_d  = d_addr_i;
                            wdata_d = d_wdata_i;
                        end
                        default: begin
                            we_d    = dbg_we_i;
                            addr_d  = dbg_addr_i;
                            wdata_d = dbg_wdata_i;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata_i;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // Outputs: RAM-side fields come straight from the latched registers,
    // so they hold their last value outside ISSUE and only mem_en_o qualifies.
    always_comb begin
        mem_en_o    = (state_q == S_ISSUE);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        busy_o      = (state_q != S_IDLE);
        gnt_id_o    = gnt_q;
        if_ack_o    = (state_q == S_DONE) && (gnt_q == GNT_IF);
        d_ack_o     = (state_q == S_DONE) && (gnt_q == GNT_D);
        dbg_ack_o   = (state_q == S_DONE) && (gnt_q == GNT_DBG);
        if_rdata_o  = rdata_q;
        d_rdata_o   = rdata_q;
        dbg_rdata_o = rdata_q;
    end

endmodule
`default_nettype wire
